// File: rtl/strobe_gen_pkg.sv
// Shared types and default widths for the multi-channel strobe generator.
package strobe_gen_pkg;

    localparam int unsigned NB_PERIOD_DEF = 8;
    localparam int unsigned N_CH_DEF      = 4;
    localparam int unsigned N_DEFAULT_DEF = 4;
    localparam int unsigned NB_FRAME_DEF  = 16;

    // Run-control FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/strobe_gen_if.sv
// Control/strobe bundle between the top-level sequencer and strobe_gen.
// Optional frame counter output is present when STROBE_GEN_FRAME_CNT_EN is defined.
interface strobe_gen_if
    import strobe_gen_pkg::*;
#(
    parameter int unsigned NB_PERIOD = NB_PERIOD_DEF,
    parameter int unsigned N_CH      = N_CH_DEF,
    parameter int unsigned NB_FRAME  = NB_FRAME_DEF
) ();

    logic                      i_enable;
    logic                      i_sync;
    logic [NB_PERIOD-1:0]      i_period;
    logic                      i_period_load;
    logic [N_CH*NB_PERIOD-1:0] i_phase;
    logic [N_CH-1:0]           o_valid;
    logic                      o_busy;
    logic                      o_err;
`ifdef STROBE_GEN_FRAME_CNT_EN
    logic [NB_FRAME-1:0]       o_frame;
`endif

    modport master (
        output i_enable, i_sync, i_period, i_period_load, i_phase,
`ifdef STROBE_GEN_FRAME_CNT_EN
        input  o_frame,
`endif
        input  o_valid, o_busy, o_err
    );

    modport slave (
        input  i_enable, i_sync, i_period, i_period_load, i_phase,
`ifdef STROBE_GEN_FRAME_CNT_EN
        output o_frame,
`endif
        output o_valid, o_busy, o_err
    );

endinterface

// File: rtl/strobe_gen_ch.sv
// One strobe channel: compares the shared counter with this channel's phase
// and registers the result, giving a one-cycle strobe one clock later.
module strobe_gen_ch #(
    parameter int unsigned NB_PERIOD = 8
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_run,
    input  logic [NB_PERIOD-1:0] i_count,
    input  logic [NB_PERIOD-1:0] i_phase,
    output logic                 o_valid
);

    logic valid_q;

    // Registered phase match; a phase the counter never reaches stays silent
    always_ff @(posedge clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= i_run && (i_count == i_phase);
        end
    end

    assign o_valid = valid_q;

endmodule

// File: rtl/strobe_gen.sv
// Multi-channel phase-offset strobe generator with a shared modulo counter.
// Period is shadow-loaded and applied at counter wrap or on resync.
// Define STROBE_GEN_FRAME_CNT_EN to add the o_frame wrap counter.
module strobe_gen
    import strobe_gen_pkg::*;
#(
    parameter int unsigned NB_PERIOD = NB_PERIOD_DEF,
    parameter int unsigned N_CH      = N_CH_DEF,
    parameter int unsigned N_DEFAULT = N_DEFAULT_DEF,
    parameter int unsigned NB_FRAME  = NB_FRAME_DEF
) (
    input logic         clk,
    input logic         i_rst,
    strobe_gen_if.slave bus
);

    localparam logic [NB_PERIOD-1:0] PERIOD_RST = NB_PERIOD'(N_DEFAULT);
    localparam logic [NB_PERIOD-1:0] ONE        = NB_PERIOD'(1);

    state_e               state_q, state_d;
    logic [NB_PERIOD-1:0] cnt_q, cnt_d;
    logic [NB_PERIOD-1:0] period_q, period_d;
    logic [NB_PERIOD-1:0] shadow_q, shadow_d;
    logic                 pend_q, pend_d;
    logic                 busy_q;
    logic                 err_q;
    logic                 run;
    logic                 wrap;
    logic                 load_ok;
    logic                 strobe_en;
    logic [N_CH-1:0]      valid;

    assign run       = (state_q == ST_RUN);
    assign wrap      = run && !bus.i_sync && (cnt_q == period_q - ONE);
    assign load_ok   = bus.i_period_load && (bus.i_period != '0);
    // The resync cycle itself never produces a strobe
    assign strobe_en = run && !bus.i_sync;

    // FSM next state: enable starts/resumes, dropping it holds
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.i_enable)  state_d = ST_RUN;
            ST_RUN:  if (!bus.i_enable) state_d = ST_HOLD;
            ST_HOLD: if (bus.i_enable)  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter and period shadowing; sync beats wrap beats increment
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        if (bus.i_sync) begin
            cnt_d = '0;
            if (pend_q) begin
                period_d = shadow_q;
                pend_d   = 1'b0;
            end
        end else if (run) begin
            if (wrap) begin
                cnt_d = '0;
                if (pend_q) begin
                    period_d = shadow_q;
                    pend_d   = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
        // A load coinciding with an apply only reaches the shadow
        if (load_ok) begin
            shadow_d = bus.i_period;
            pend_d   = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= PERIOD_RST;
            shadow_q <= PERIOD_RST;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            busy_q   <= (state_d == ST_RUN);
            err_q    <= bus.i_period_load && (bus.i_period == '0);
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        strobe_gen_ch #(
            .NB_PERIOD (NB_PERIOD)
        ) u_ch (
            .clk     (clk),
            .i_rst   (i_rst),
            .i_run   (strobe_en),
            .i_count (cnt_q),
            .i_phase (bus.i_phase[k*NB_PERIOD +: NB_PERIOD]),
            .o_valid (valid[k])
        );
    end

    assign bus.o_valid = valid;
    assign bus.o_busy  = busy_q;
    assign bus.o_err   = err_q;

`ifdef STROBE_GEN_FRAME_CNT_EN
    logic [NB_FRAME-1:0] frame_q;

    // Frame counter: counts RUN wraps, cleared by reset and resync
    always_ff @(posedge clk) begin
        if (i_rst || bus.i_sync) begin
            frame_q <= '0;
        end else if (wrap) begin
            frame_q <= frame_q + NB_FRAME'(1);
        end
    end

    assign bus.o_frame = frame_q;
`endif

endmodule

// File: tb/tb_strobe_gen.sv
// Self-checking bench for strobe_gen: cycle model plus directed literal checks.
module tb_strobe_gen;

    localparam int NBP  = 8;
    localparam int NCH  = 4;
    localparam int NDEF = 4;
    localparam int NBF  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    strobe_gen_if #(.NB_PERIOD(NBP), .N_CH(NCH), .NB_FRAME(NBF)) bus ();

    strobe_gen #(
        .NB_PERIOD (NBP),
        .N_CH      (NCH),
        .N_DEFAULT (NDEF),
        .NB_FRAME  (NBF)
    ) dut (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    bit chk_on = 1'b0;

    // Model: mode 0=idle 1=run 2=hold
    int       m_mode, m_cnt, m_per, m_sh, m_frame;
    bit       m_pend;
    bit [3:0] e_valid;
    bit       e_busy, e_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic model_step();
        int ph;
        bit running;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_per = NDEF; m_sh = NDEF; m_pend = 0; m_frame = 0;
            e_valid = '0; e_busy = 0; e_err = 0;
        end else begin
            running = (m_mode == 1);
            for (int k = 0; k < NCH; k++) begin
                ph = int'(bus.i_phase[k*NBP +: NBP]);
                e_valid[k] = running && !bus.i_sync && (m_cnt == ph);
            end
            e_err = bus.i_period_load && (bus.i_period == 0);
            if (bus.i_sync) begin
                m_cnt = 0;
                m_frame = 0;
                if (m_pend) begin m_per = m_sh; m_pend = 0; end
            end else if (running) begin
                if (m_cnt == m_per - 1) begin
                    m_cnt = 0;
                    m_frame = (m_frame + 1) % (1 << NBF);
                    if (m_pend) begin m_per = m_sh; m_pend = 0; end
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (bus.i_period_load && bus.i_period != 0) begin
                m_sh = int'(bus.i_period);
                m_pend = 1;
            end
            if (m_mode == 0 && bus.i_enable)       m_mode = 1;
            else if (m_mode == 1 && !bus.i_enable) m_mode = 2;
            else if (m_mode == 2 && bus.i_enable)  m_mode = 1;
            e_busy = (m_mode == 1);
        end
    endtask

    // Model advances on the same edge the DUT samples
    always @(posedge clk) begin
        edge_cnt++;
        model_step();
        if (rst) chk_on = 1'b1;
    end

    // Compare process, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("valid", bus.o_valid, e_valid);
            check("busy", bus.o_busy, e_busy);
            check("err", bus.o_err, e_err);
`ifdef STROBE_GEN_FRAME_CNT_EN
            check("frame", bus.o_frame, m_frame);
`endif
        end
    end

    task automatic wait_ch0(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_valid[0] === 1'b1) begin
                at = edge_cnt;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_ch0: no strobe within 40 cycles (edge %0d)", edge_cnt);
        end
    endtask

    initial begin
        int s, t0, t1, tp, n3;
        rst = 1'b1;
        bus.i_enable = 1'b0; bus.i_sync = 1'b0;
        bus.i_period = '0;   bus.i_period_load = 1'b0;
        bus.i_phase = {8'd3, 8'd3, 8'd3, 8'd3};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", bus.o_busy, 0);
        check("rst_valid", bus.o_valid, 0);

        // All phases 3, default period 4
        bus.i_enable = 1'b1;
        s = edge_cnt;
        @(negedge clk);
        check("busy_after_enable", bus.o_busy, 1);
        wait_ch0(t0);
        check("first_strobe_latency", t0 - s, 5);
        check("first_strobe_all", bus.o_valid, 4'hF);
        wait_ch0(t1);
        check("period4_gap", t1 - t0, 4);

        // Rotating phases
        bus.i_phase = {8'd3, 8'd2, 8'd1, 8'd0};
        wait_ch0(t0);
        wait_ch0(t0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("rotation", bus.o_valid, 32'(1 << i));
        end

        // Rejected zero-period load
        bus.i_period = 8'd0; bus.i_period_load = 1'b1;
        @(negedge clk);
        check("err_pulse", bus.o_err, 1);
        bus.i_period_load = 1'b0;
        @(negedge clk);
        check("err_one_cycle", bus.o_err, 0);
        wait_ch0(t0);
        wait_ch0(t1);
        check("period_kept_4", t1 - t0, 4);

        // Load 6 while counter=1: current frame still 4, next 6
        bus.i_period = 8'd6; bus.i_period_load = 1'b1;
        @(negedge clk);
        bus.i_period_load = 1'b0;
        wait_ch0(t0);
        check("frame_end_old", t0 - t1, 4);
        wait_ch0(t1);
        check("period6_gap", t1 - t0, 6);

        // Hold for 3 cycles starting at counter=2
        @(negedge clk);
        bus.i_enable = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_enable = 1'b1;
        wait_ch0(t0);
        check("hold_gap", t0 - t1, 9);

        // Pending load 5, then sync at counter=2
        bus.i_period = 8'd5; bus.i_period_load = 1'b1;
        @(negedge clk);
        bus.i_period_load = 1'b0; bus.i_sync = 1'b1;
        @(negedge clk);
        bus.i_sync = 1'b0;
        check("sync_no_strobe", bus.o_valid, 0);
`ifdef STROBE_GEN_FRAME_CNT_EN
        check("sync_frame_zero", bus.o_frame, 0);
`endif
        wait_ch0(t1);
        check("sync_restart", t1 - t0, 3);
        wait_ch0(tp);
        check("period5_gap", tp - t1, 5);

        // Phase beyond period stays silent
        bus.i_phase = {8'd7, 8'd2, 8'd1, 8'd0};
        n3 = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.o_valid[3]) n3++;
        end
        check("silent_ch3", n3, 0);

        // Period 1 applied via sync
        bus.i_phase = {8'd0, 8'd0, 8'd1, 8'd0};
        bus.i_period = 8'd1; bus.i_period_load = 1'b1;
        @(negedge clk);
        bus.i_period_load = 1'b0; bus.i_sync = 1'b1;
        @(negedge clk);
        bus.i_sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("period1_cont", bus.o_valid, 4'hD);
        end

        // Reset mid-run discards a pending load
        bus.i_phase = {8'd3, 8'd3, 8'd3, 8'd3};
        bus.i_period = 8'd7; bus.i_period_load = 1'b1;
        @(negedge clk);
        bus.i_period_load = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", bus.o_busy, 0);
        check("midrst_valid", bus.o_valid, 0);
        wait_ch0(t0);
        wait_ch0(t1);
        check("midrst_period4", t1 - t0, 4);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (edge %0d)", edge_cnt);
        $fatal(1, "watchdog");
    end

endmodule
